// File: rtl/bj_round_fsm_pkg.sv
// +----------------------------------------------------------------------------+
// | bj_round_fsm_pkg : state/outcome encodings and hand arithmetic for the       |
// |                    blackjack round controller.                               |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

package bj_round_fsm_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_DEAL_P1 = 4'd1,
    ST_DEAL_D1 = 4'd2,
    ST_DEAL_P2 = 4'd3,
    ST_DEAL_D2 = 4'd4,
    ST_PLAYER  = 4'd5,
    ST_P_HIT   = 4'd6,
    ST_DEALER  = 4'd7,
    ST_D_HIT   = 4'd8,
    ST_DONE    = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    OUT_NONE = 2'b00,
    OUT_WIN  = 2'b01,
    OUT_LOSE = 2'b10,
    OUT_PUSH = 2'b11
  } outcome_t;

  localparam logic [5:0] BUST_LIMIT = 6'd21;
  localparam logic [3:0] ACE_LO     = 4'd1;
  localparam logic [3:0] ACE_HI     = 4'd11;
  localparam logic [6:0] ACE_ADJ    = 7'd10;

  function automatic logic is_card(input logic [3:0] v);
    return (v >= ACE_LO) && (v <= ACE_HI);
  endfunction

  // Returns {soft_aces, total}. Two demotions cover a new ace landing on a
  // hand that already holds a soft ace (e.g. soft 21 + ace = 32 -> 22 -> 12).
  function automatic logic [8:0] hand_add(input logic [5:0] total,
                                          input logic [2:0] aces,
                                          input logic [3:0] v);
    logic [6:0] t;
    logic [2:0] a;
    if (v == ACE_LO || v == ACE_HI) begin
      t = {1'b0, total} + {3'b000, ACE_HI};
      a = aces + 3'd1;
    end else begin
      t = {1'b0, total} + {3'b000, v};
      a = aces;
    end
    for (int i = 0; i < 2; i++) begin
      if (t > {1'b0, BUST_LIMIT} && a != 3'd0) begin
        t = t - ACE_ADJ;
        a = a - 3'd1;
      end
    end
    return {a, t[5:0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/bj_round_fsm_if.sv
// +----------------------------------------------------------------------------+
// | bj_round_fsm_if : card request/valid handshake to the card generator.        |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

interface bj_round_fsm_if;
  logic       card_req;
  logic       card_valid;
  logic [3:0] card_value;

  modport master (output card_req, input card_valid, input card_value);
  modport slave  (input card_req, output card_valid, output card_value);
endinterface

`default_nettype wire

// File: rtl/bj_round_fsm_hand.sv
// +----------------------------------------------------------------------------+
// | bj_hand_accum : one hand's total, soft-ace count and card count.             |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module bj_hand_accum
  import bj_round_fsm_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       clr,
  input  logic       add,
  input  logic [3:0] value,
  output logic [5:0] total,
  output logic [3:0] count
);

  logic [5:0] r_total;
  logic [2:0] r_soft_aces;
  logic [3:0] r_count;
  logic [8:0] w_sum;

  assign w_sum = hand_add(r_total, r_soft_aces, value);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_total     <= 6'd0;
      r_soft_aces <= 3'd0;
      r_count     <= 4'd0;
    end else if (clr) begin
      r_total     <= 6'd0;
      r_soft_aces <= 3'd0;
      r_count     <= 4'd0;
    end else if (add) begin
      r_total     <= w_sum[5:0];
      r_soft_aces <= w_sum[8:6];
      r_count     <= r_count + 4'd1;
    end
  end

  assign total = r_total;
  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/bj_round_fsm.sv
// +----------------------------------------------------------------------------+
// | bj_round_fsm : blackjack round controller - deal, player, dealer, score.     |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module bj_round_fsm
  import bj_round_fsm_pkg::*;
#(
  parameter int DEALER_STAND = 17,
  parameter int MAX_CARDS    = 8
)
(
  input  logic                  CLOCK_50,
  input  logic                  resetn,
  input  logic                  new_game,
  input  logic                  hit,
  input  logic                  stand,
  bj_round_fsm_if.master        card_if,
  output logic [5:0]            player_total,
  output logic [5:0]            dealer_total,
  output logic [3:0]            player_cards,
  output logic [3:0]            dealer_cards,
  output logic [1:0]            outcome,
  output logic                  round_done
);

  localparam logic [5:0] c_DEALER_STAND = 6'(DEALER_STAND);
  localparam logic [3:0] c_MAX_CARDS    = 4'(MAX_CARDS);

  state_t   r_state, w_next;
  outcome_t r_outcome, w_outcome;
  logic     r_got;
  logic     r_hold;
  logic     w_card_state, w_player_card, w_req, w_accept;

  always_comb begin
    w_card_state  = 1'b0;
    w_player_card = 1'b0;
    case (r_state)
      ST_DEAL_P1, ST_DEAL_P2, ST_P_HIT: begin
        w_card_state  = 1'b1;
        w_player_card = 1'b1;
      end
      ST_DEAL_D1, ST_DEAL_D2, ST_D_HIT: w_card_state = 1'b1;
      default: ;
    endcase
  end

  // r_got holds the request low while the FSM evaluates the freshly updated
  // total; r_hold drops it for one cycle after a restart.
  assign w_req    = w_card_state & ~r_got & ~r_hold;
  assign w_accept = w_req & card_if.card_valid & is_card(card_if.card_value);
  assign card_if.card_req = w_req;

  bj_hand_accum u_player (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .clr      (new_game),
    .add      (w_accept & w_player_card),
    .value    (card_if.card_value),
    .total    (player_total),
    .count    (player_cards)
  );

  bj_hand_accum u_dealer (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .clr      (new_game),
    .add      (w_accept & ~w_player_card),
    .value    (card_if.card_value),
    .total    (dealer_total),
    .count    (dealer_cards)
  );

  always_comb begin
    w_next    = r_state;
    w_outcome = r_outcome;
    case (r_state)
      ST_DEAL_P1: if (r_got) w_next = ST_DEAL_D1;
      ST_DEAL_D1: if (r_got) w_next = ST_DEAL_P2;
      ST_DEAL_P2: if (r_got) w_next = ST_DEAL_D2;
      ST_DEAL_D2: if (r_got) w_next = (player_total == BUST_LIMIT) ? ST_DEALER : ST_PLAYER;
      ST_PLAYER: begin
        if (player_total == BUST_LIMIT || player_cards == c_MAX_CARDS || stand)
          w_next = ST_DEALER;
        else if (hit)
          w_next = ST_P_HIT;
      end
      ST_P_HIT: begin
        if (r_got) begin
          if (player_total > BUST_LIMIT) begin
            w_next    = ST_DONE;
            w_outcome = OUT_LOSE;
          end else begin
            w_next = ST_PLAYER;
          end
        end
      end
      ST_DEALER: begin
        if (dealer_total >= c_DEALER_STAND || dealer_cards == c_MAX_CARDS) begin
          w_next = ST_DONE;
          if (player_total > dealer_total)      w_outcome = OUT_WIN;
          else if (player_total < dealer_total) w_outcome = OUT_LOSE;
          else                                  w_outcome = OUT_PUSH;
        end else begin
          w_next = ST_D_HIT;
        end
      end
      ST_D_HIT: begin
        if (r_got) begin
          if (dealer_total > BUST_LIMIT) begin
            w_next    = ST_DONE;
            w_outcome = OUT_WIN;
          end else begin
            w_next = ST_DEALER;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_outcome <= OUT_NONE;
      r_got     <= 1'b0;
      r_hold    <= 1'b0;
    end else if (new_game) begin
      r_state   <= ST_DEAL_P1;
      r_outcome <= OUT_NONE;
      r_got     <= 1'b0;
      r_hold    <= 1'b1;
    end else begin
      r_state   <= w_next;
      r_outcome <= w_outcome;
      r_got     <= w_accept;
      r_hold    <= 1'b0;
    end
  end

  assign outcome    = r_outcome;
  assign round_done = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_bj_round_fsm.sv
// Self-checking bench for bj_round_fsm: directed rounds plus randomized rounds
// scored by a card-list blackjack model.
`default_nettype none

module tb_bj_round_fsm;

  logic CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  logic       resetn, new_game, hit, stand;
  logic [5:0] player_total, dealer_total;
  logic [3:0] player_cards, dealer_cards;
  logic [1:0] outcome;
  logic       round_done;
  logic [22:0] w_obs;
  logic [22:0] exp_obs;

  int n_cmp = 0;
  int n_bad = 0;

  bj_round_fsm_if cif ();

  bj_round_fsm #(.DEALER_STAND(17), .MAX_CARDS(8)) dut (
    .CLOCK_50     (CLOCK_50),
    .resetn       (resetn),
    .new_game     (new_game),
    .hit          (hit),
    .stand        (stand),
    .card_if      (cif),
    .player_total (player_total),
    .dealer_total (dealer_total),
    .player_cards (player_cards),
    .dealer_cards (dealer_cards),
    .outcome      (outcome),
    .round_done   (round_done)
  );

  assign w_obs = {player_total, dealer_total, player_cards, dealer_cards, outcome, round_done};

  // Best blackjack total of a card list: count aces as 1, promote one if it fits.
  function automatic int best_total(input int h[$]);
    int s = 0;
    bit ace = 0;
    foreach (h[i]) begin
      if (h[i] == 1 || h[i] == 11) begin s += 1; ace = 1; end
      else s += h[i];
    end
    if (ace && s + 10 <= 21) s += 10;
    return s;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic pulse_ng();
    new_game = 1'b1;
    @(negedge CLOCK_50);
    new_game = 1'b0;
  endtask

  task automatic pulse_hs(input logic h, input logic s);
    hit = h; stand = s;
    @(negedge CLOCK_50);
    hit = 1'b0; stand = 1'b0;
  endtask

  task automatic give_card(input logic [3:0] v);
    int n = 0;
    while (cif.card_req !== 1'b1 && n < 40) begin @(negedge CLOCK_50); n++; end
    n_cmp++;
    if (cif.card_req !== 1'b1) begin
      n_bad++;
      $display("FAIL card_req_wait: card_req=%b required 1 (card %0d)", cif.card_req, v);
    end else begin
      cif.card_valid = 1'b1; cif.card_value = v;
      @(negedge CLOCK_50);
      cif.card_valid = 1'b0; cif.card_value = 4'd0;
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (round_done !== 1'b1 && n < 40) begin @(negedge CLOCK_50); n++; end
  endtask

  task automatic deal4(input int a, input int b, input int c, input int d);
    pulse_ng();
    give_card(4'(a)); give_card(4'(b)); give_card(4'(c)); give_card(4'(d));
    tick(3);
  endtask

  task automatic test_reset();
    resetn = 1'b0; new_game = 1'b0; hit = 1'b0; stand = 1'b0;
    cif.card_valid = 1'b0; cif.card_value = 4'd0;
    tick(2);
    n_cmp++;
    if (w_obs !== 23'd0 || cif.card_req !== 1'b0) begin
      n_bad++; $display("FAIL reset_outputs: got %h req=%b required 0 req=0", w_obs, cif.card_req);
    end
    resetn = 1'b1;
    tick(2);
    n_cmp++;
    if (w_obs !== 23'd0 || cif.card_req !== 1'b0) begin
      n_bad++; $display("FAIL idle_after_reset: got %h req=%b required 0 req=0", w_obs, cif.card_req);
    end
  endtask

  task automatic test_stand_win();
    deal4(10, 7, 9, 10);
    exp_obs = {6'd19, 6'd17, 4'd2, 4'd2, 2'b00, 1'b0};
    n_cmp++;
    if (w_obs !== exp_obs) begin n_bad++; $display("FAIL s1_deal: got %h required %h", w_obs, exp_obs); end
    pulse_hs(1'b0, 1'b1);
    wait_done();
    exp_obs = {6'd19, 6'd17, 4'd2, 4'd2, 2'b01, 1'b1};
    n_cmp++;
    if (w_obs !== exp_obs || cif.card_req !== 1'b0) begin
      n_bad++; $display("FAIL s1_done: got %h req=%b required %h req=0", w_obs, cif.card_req, exp_obs);
    end
  endtask

  task automatic test_ace_adjust();
    deal4(11, 5, 11, 6);
    exp_obs = {6'd12, 6'd11, 4'd2, 4'd2, 2'b00, 1'b0};
    n_cmp++;
    if (w_obs !== exp_obs) begin n_bad++; $display("FAIL s2_deal: got %h required %h", w_obs, exp_obs); end
    pulse_hs(1'b1, 1'b0);
    give_card(4'd10);
    tick(3);
    exp_obs = {6'd12, 6'd11, 4'd3, 4'd2, 2'b00, 1'b0};
    n_cmp++;
    if (w_obs !== exp_obs) begin n_bad++; $display("FAIL s2_hit_adjust: got %h required %h", w_obs, exp_obs); end
    // Both aces are now hard, so another ten must bust.
    pulse_hs(1'b1, 1'b0);
    give_card(4'd10);
    tick(3);
    exp_obs = {6'd22, 6'd11, 4'd4, 4'd2, 2'b10, 1'b1};
    n_cmp++;
    if (w_obs !== exp_obs) begin n_bad++; $display("FAIL s2_no_soft_left: got %h required %h", w_obs, exp_obs); end
  endtask

  task automatic test_player_bust();
    deal4(10, 6, 10, 10);
    pulse_hs(1'b1, 1'b0);
    give_card(4'd5);
    tick(3);
    exp_obs = {6'd25, 6'd16, 4'd3, 4'd2, 2'b10, 1'b1};
    n_cmp++;
    if (w_obs !== exp_obs || cif.card_req !== 1'b0) begin
      n_bad++; $display("FAIL s3_bust: got %h req=%b required %h req=0", w_obs, cif.card_req, exp_obs);
    end
  endtask

  task automatic test_dealer_bust();
    deal4(9, 10, 8, 6);
    pulse_hs(1'b0, 1'b1);
    give_card(4'd10);
    wait_done();
    exp_obs = {6'd17, 6'd26, 4'd2, 4'd3, 2'b01, 1'b1};
    n_cmp++;
    if (w_obs !== exp_obs) begin n_bad++; $display("FAIL s4_dealer_bust: got %h required %h", w_obs, exp_obs); end
  endtask

  task automatic test_handshake();
    pulse_ng();
    n_cmp++;
    if (w_obs !== 23'd0 || cif.card_req !== 1'b0) begin
      n_bad++; $display("FAIL hs_restart_drop: got %h req=%b required 0 req=0", w_obs, cif.card_req);
    end
    cif.card_valid = 1'b1; cif.card_value = 4'd5;
    @(negedge CLOCK_50);
    cif.card_valid = 1'b0; cif.card_value = 4'd0;
    n_cmp++;
    if (player_cards !== 4'd0 || cif.card_req !== 1'b1) begin
      n_bad++; $display("FAIL hs_valid_while_idle: cards=%0d req=%b required 0 req=1", player_cards, cif.card_req);
    end
    for (int i = 0; i < 2; i++) begin
      cif.card_valid = 1'b1; cif.card_value = (i == 0) ? 4'd0 : 4'd13;
      @(negedge CLOCK_50);
      cif.card_valid = 1'b0; cif.card_value = 4'd0;
      n_cmp++;
      if (player_cards !== 4'd0 || player_total !== 6'd0 || cif.card_req !== 1'b1) begin
        n_bad++; $display("FAIL hs_bad_value_%0d: cards=%0d total=%0d req=%b required 0 0 req=1",
                          i, player_cards, player_total, cif.card_req);
      end
    end
    cif.card_valid = 1'b1; cif.card_value = 4'd4;
    @(negedge CLOCK_50);
    cif.card_valid = 1'b0; cif.card_value = 4'd0;
    n_cmp++;
    if (player_total !== 6'd4 || player_cards !== 4'd1 || cif.card_req !== 1'b0) begin
      n_bad++; $display("FAIL hs_accept: total=%0d cards=%0d req=%b required 4 1 req=0",
                        player_total, player_cards, cif.card_req);
    end
    tick(1);
    n_cmp++;
    if (cif.card_req !== 1'b1 || dealer_cards !== 4'd0) begin
      n_bad++; $display("FAIL hs_reraise: req=%b dcards=%0d required req=1 dcards=0", cif.card_req, dealer_cards);
    end
  endtask

  task automatic test_controls();
    int n = 0;
    deal4(10, 7, 9, 10);
    pulse_hs(1'b1, 1'b1);
    wait_done();
    exp_obs = {6'd19, 6'd17, 4'd2, 4'd2, 2'b01, 1'b1};
    n_cmp++;
    if (w_obs !== exp_obs) begin n_bad++; $display("FAIL hit_and_stand: got %h required %h", w_obs, exp_obs); end

    deal4(10, 10, 5, 6);
    pulse_hs(1'b0, 1'b1);
    while (cif.card_req !== 1'b1 && n < 40) begin @(negedge CLOCK_50); n++; end
    n_cmp++;
    if (cif.card_req !== 1'b1 || dealer_total !== 6'd16) begin
      n_bad++; $display("FAIL dealer_req: req=%b dtotal=%0d required req=1 dtotal=16", cif.card_req, dealer_total);
    end
    pulse_ng();
    n_cmp++;
    if (w_obs !== 23'd0 || cif.card_req !== 1'b0) begin
      n_bad++; $display("FAIL new_game_in_dhit: got %h req=%b required 0 req=0", w_obs, cif.card_req);
    end
    tick(1);
    n_cmp++;
    if (cif.card_req !== 1'b1) begin n_bad++; $display("FAIL new_game_reraise: req=%b required 1", cif.card_req); end

    give_card(4'd10);
    give_card(4'd7);
    n = 0;
    while (cif.card_req !== 1'b1 && n < 40) begin @(negedge CLOCK_50); n++; end
    n_cmp++;
    if (cif.card_req !== 1'b1 || w_obs !== {6'd10, 6'd7, 4'd1, 4'd1, 2'b00, 1'b0}) begin
      n_bad++; $display("FAIL deal_p2_reached: got %h req=%b", w_obs, cif.card_req);
    end
    #3 resetn = 1'b0;
    #1;
    n_cmp++;
    if (w_obs !== 23'd0 || cif.card_req !== 1'b0) begin
      n_bad++; $display("FAIL async_reset: got %h req=%b required 0 req=0", w_obs, cif.card_req);
    end
    @(negedge CLOCK_50);
    resetn = 1'b1;
    tick(2);
    n_cmp++;
    if (w_obs !== 23'd0 || cif.card_req !== 1'b0) begin
      n_bad++; $display("FAIL post_reset_idle: got %h req=%b required 0 req=0", w_obs, cif.card_req);
    end
  endtask

  task automatic test_random(input int rounds);
    for (int r = 0; r < rounds; r++) begin
      int pc[$];
      int dc[$];
      int v, thr, ep, ed;
      bit bust;
      logic [1:0] eo;
      pc = {}; dc = {}; bust = 0;
      pulse_ng();
      for (int k = 0; k < 4; k++) begin
        v = $urandom_range(1, 11);
        if (k % 2 == 0) pc.push_back(v); else dc.push_back(v);
        give_card(4'(v));
      end
      tick(3);
      n_cmp++;
      if (w_obs[22:3] !== {6'(best_total(pc)), 6'(best_total(dc)), 4'd2, 4'd2}) begin
        n_bad++; $display("FAIL rnd%0d_deal: got %h required p=%0d d=%0d", r, w_obs, best_total(pc), best_total(dc));
      end
      thr = $urandom_range(12, 20);
      while (best_total(pc) != 21 && pc.size() < 8 && !bust) begin
        if (best_total(pc) < thr) begin
          pulse_hs(1'b1, 1'b0);
          v = $urandom_range(1, 11);
          pc.push_back(v);
          give_card(4'(v));
          tick(3);
          if (best_total(pc) > 21) bust = 1;
        end else begin
          pulse_hs(1'b0, 1'b1);
          break;
        end
      end
      if (!bust) begin
        while (best_total(dc) < 17 && dc.size() < 8) begin
          v = $urandom_range(1, 11);
          dc.push_back(v);
          give_card(4'(v));
        end
      end
      wait_done();
      ep = best_total(pc);
      ed = best_total(dc);
      if (bust)         eo = 2'b10;
      else if (ed > 21) eo = 2'b01;
      else if (ep > ed) eo = 2'b01;
      else if (ep < ed) eo = 2'b10;
      else              eo = 2'b11;
      exp_obs = {6'(ep), 6'(ed), 4'(pc.size()), 4'(dc.size()), eo, 1'b1};
      n_cmp++;
      if (w_obs !== exp_obs || cif.card_req !== 1'b0) begin
        n_bad++; $display("FAIL rnd%0d_result: got %h req=%b required %h req=0", r, w_obs, cif.card_req, exp_obs);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stand_win();
    test_ace_adjust();
    test_player_bust();
    test_dealer_bust();
    test_handshake();
    test_controls();
    test_random(40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
